// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Multi-cycle controller in front of a combinational ALU.
//                Latches operands, drives a one-hot ALU control vector for a
//                per-operation settle window, captures HI/LO results and
//                pulses done (with error for traps).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int BITS       = 32,
  parameter int SIG_COUNT  = 12,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [BITS-1:0]      a_in,
  input  logic [BITS-1:0]      b_in,
  output logic [BITS-1:0]      alu_x,
  output logic [BITS-1:0]      alu_y,
  output logic [SIG_COUNT-1:0] alu_ctrl,
  input  logic [BITS-1:0]      alu_hi,
  input  logic [BITS-1:0]      alu_lo,
  output logic [BITS-1:0]      z_hi,
  output logic [BITS-1:0]      z_lo,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int c_max_cycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_exec = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [3:0] c_op_mul  = 4'd2;
  localparam logic [3:0] c_op_div  = 4'd3;
  localparam logic [3:0] c_num_ops = 4'd12;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_load_cnt;
  logic               r_wide;
  logic               r_err;
  logic               w_trap;
  logic               w_accept;
  logic               w_last;

  // Illegal opcode or division by zero never reaches the ALU.
  assign w_trap   = (op >= c_num_ops) || ((op == c_op_div) && (b_in == '0));
  assign w_accept = (r_state == c_idle) && start && !w_trap;
  // Treat a zero count as final too, so EXEC can never stall.
  assign w_last   = (r_cnt <= c_cnt_w'(1));

  // Settle window length for the requested operation.
  always_comb begin
    w_load_cnt = c_cnt_w'(1);
    if (op == c_op_mul) begin
      w_load_cnt = c_cnt_w'(MUL_CYCLES);
    end else if (op == c_op_div) begin
      w_load_cnt = c_cnt_w'(DIV_CYCLES);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (start) begin
          w_next_state = w_trap ? c_done : c_exec;
        end
      end
      c_exec: begin
        if (w_last) begin
          w_next_state = c_done;
        end
      end
      c_done:  w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // Status outputs decoded from state; error only qualifies the done cycle.
  always_comb begin
    busy  = (r_state != c_idle);
    done  = (r_state == c_done);
    error = (r_state == c_done) && r_err;
  end

  // Operand latch, control vector, settle counter and result capture.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      alu_x    <= '0;
      alu_y    <= '0;
      alu_ctrl <= '0;
      z_hi     <= '0;
      z_lo     <= '0;
      r_cnt    <= '0;
      r_wide   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= (r_state == c_idle) && start && w_trap;
      if (w_accept) begin
        alu_x    <= a_in;
        alu_y    <= b_in;
        alu_ctrl <= SIG_COUNT'(1) << op;
        r_cnt    <= w_load_cnt;
        r_wide   <= (op == c_op_mul) || (op == c_op_div);
      end else if (r_state == c_exec) begin
        r_cnt <= r_cnt - c_cnt_w'(1);
        if (w_last) begin
          z_lo     <= alu_lo;
          // HI is only driven by the ALU for multiply and divide.
          z_hi     <= r_wide ? alu_hi : '0;
          alu_ctrl <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer with a behavioural
//                ALU stand-in and a reference result model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  localparam int BITS       = 32;
  localparam int SIG_COUNT  = 12;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 8;

  logic                 clk;
  logic                 clr;
  logic                 start;
  logic [3:0]           op;
  logic [BITS-1:0]      a_in, b_in;
  logic [BITS-1:0]      alu_x, alu_y;
  logic [SIG_COUNT-1:0] alu_ctrl;
  logic [BITS-1:0]      alu_hi, alu_lo;
  logic [BITS-1:0]      z_hi, z_lo;
  logic                 busy, done, error;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer #(
    .BITS(BITS), .SIG_COUNT(SIG_COUNT), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl), .alu_hi(alu_hi), .alu_lo(alu_lo),
    .z_hi(z_hi), .z_lo(z_lo), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU stand-in; HI is junk unless multiply/divide, outputs junk when idle.
  always_comb begin
    logic [63:0] prod;
    logic [4:0]  sh;
    prod   = {32'd0, alu_x} * {32'd0, alu_y};
    sh     = alu_y[4:0];
    alu_hi = 32'hDEAD_BEEF;
    alu_lo = 32'hBAD0_BAD0;
    case (alu_ctrl)
      12'h001: alu_lo = alu_x + alu_y;
      12'h002: alu_lo = alu_x - alu_y;
      12'h004: begin alu_hi = prod[63:32]; alu_lo = prod[31:0]; end
      12'h008: if (alu_y != 0) begin alu_hi = alu_x % alu_y; alu_lo = alu_x / alu_y; end
      12'h010: alu_lo = alu_x >> sh;
      12'h020: alu_lo = alu_x << sh;
      12'h040: alu_lo = (sh == 0) ? alu_x : ((alu_x >> sh) | (alu_x << (6'd32 - {1'b0, sh})));
      12'h080: alu_lo = (sh == 0) ? alu_x : ((alu_x << sh) | (alu_x >> (6'd32 - {1'b0, sh})));
      12'h100: alu_lo = alu_x & alu_y;
      12'h200: alu_lo = alu_x | alu_y;
      12'h400: alu_lo = ~alu_x + 32'd1;
      12'h800: alu_lo = ~alu_x;
      default: ;
    endcase
  end

  // Reference result {hi, lo} for a legal operation.
  function automatic logic [63:0] ref_z(input int o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] dbl;
    dbl = {a, a};
    case (o)
      0:  return {32'd0, a + b};
      1:  return {32'd0, a - b};
      2:  return {32'd0, a} * {32'd0, b};
      3:  return {a % b, a / b};
      4:  return {32'd0, a >> b[4:0]};
      5:  return {32'd0, a << b[4:0]};
      6:  return {32'd0, dbl[31:0] >> 0 == 0 ? 32'd0 : 32'd0} | {32'd0, 32'(dbl >> b[4:0])};
      7:  return {32'd0, 32'((dbl << b[4:0]) >> 32)};
      8:  return {32'd0, a & b};
      9:  return {32'd0, a | b};
      10: return {32'd0, 32'd0 - a};
      11: return {32'd0, ~a};
      default: return 64'd0;
    endcase
  endfunction

  function automatic int n_of(input int o);
    return (o == 2) ? MUL_CYCLES : (o == 3) ? DIV_CYCLES : 1;
  endfunction

  // Issue one request and record what the DUT did until it returns to IDLE.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int lat, output logic err,
                        output int ctrl_cyc, output int ctrl_bad, output int busy_bad,
                        output logic idle_after);
    logic [11:0] exp_ctrl;
    exp_ctrl = (o < 12) ? (12'd1 << o) : 12'd0;
    lat = -1; err = 1'b0; ctrl_cyc = 0; ctrl_bad = 0; busy_bad = 0;
    start = 1'b1; op = o; a_in = a; b_in = b;
    for (int i = 0; i < 64 && lat < 0; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      a_in = $urandom; b_in = $urandom;
      if (busy !== 1'b1) busy_bad++;
      if (alu_ctrl !== 12'd0) begin
        ctrl_cyc++;
        if (alu_ctrl !== exp_ctrl) ctrl_bad++;
      end
      if (done === 1'b1) begin lat = i; err = error; end
    end
    @(negedge clk);
    start = 1'b0;
    idle_after = (busy === 1'b0) && (done === 1'b0) && (alu_ctrl === 12'd0);
  endtask

  task automatic test_reset;
    clr = 1'b1; start = 1'b0; op = 4'd0; a_in = '0; b_in = '0;
    #2 clr = 1'b0;
    #1;
    n_checks++; if ({alu_x, alu_y} !== 64'd0) begin n_fail++; $display("FAIL reset_operands: got %h expected 0", {alu_x, alu_y}); end
    n_checks++; if (alu_ctrl !== 12'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", alu_ctrl); end
    n_checks++; if ({z_hi, z_lo} !== 64'd0) begin n_fail++; $display("FAIL reset_z: got %h expected 0", {z_hi, z_lo}); end
    n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, error}); end
    repeat (2) @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_add;
    int lat, cc, cb, bb; logic err, idle;
    run_op(4'd0, 32'd5, 32'd7, 1'b0, lat, err, cc, cb, bb, idle);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
    n_checks++; if ({cc, cb} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL add_ctrl: got %0d cycles %0d bad expected 1/0", cc, cb); end
    n_checks++; if ({z_hi, z_lo} !== {32'd0, 32'd12}) begin n_fail++; $display("FAIL add_z: got %h expected %h", {z_hi, z_lo}, {32'd0, 32'd12}); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL add_error: got %b expected 0", err); end
    n_checks++; if ({alu_x, alu_y} !== {32'd5, 32'd7}) begin n_fail++; $display("FAIL add_hold_operands: got %h expected %h", {alu_x, alu_y}, {32'd5, 32'd7}); end
    n_checks++; if ({idle, bb} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL add_busy: got idle %b busy_bad %0d expected 1/0", idle, bb); end
  endtask

  task automatic test_multiply;
    int lat, cc, cb, bb; logic err, idle;
    run_op(4'd2, 32'h0001_0000, 32'h0001_0000, 1'b0, lat, err, cc, cb, bb, idle);
    n_checks++; if (lat !== MUL_CYCLES) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", lat, MUL_CYCLES); end
    n_checks++; if ({cc, cb} !== {MUL_CYCLES, 32'd0}) begin n_fail++; $display("FAIL mul_ctrl: got %0d cycles %0d bad", cc, cb); end
    n_checks++; if ({z_hi, z_lo} !== 64'h1_0000_0000) begin n_fail++; $display("FAIL mul_z: got %h expected 0000000100000000", {z_hi, z_lo}); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mul_error: got %b expected 0", err); end
  endtask

  task automatic test_div_by_zero;
    int lat, cc, cb, bb; logic err, idle; logic [63:0] prev;
    prev = {z_hi, z_lo};
    run_op(4'd3, 32'd9, 32'd0, 1'b0, lat, err, cc, cb, bb, idle);
    n_checks++; if ({lat, err} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL div0_trap: got lat %0d err %b expected 0/1", lat, err); end
    n_checks++; if (cc !== 0) begin n_fail++; $display("FAIL div0_ctrl: got %0d active cycles expected 0", cc); end
    n_checks++; if ({z_hi, z_lo} !== prev) begin n_fail++; $display("FAIL div0_z_kept: got %h expected %h", {z_hi, z_lo}, prev); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL div0_idle: got %b expected 1", idle); end
    run_op(4'd3, 32'd9, 32'd2, 1'b0, lat, err, cc, cb, bb, idle);
    n_checks++; if ({lat, err} !== {DIV_CYCLES, 1'b0}) begin n_fail++; $display("FAIL div_done: got lat %0d err %b expected %0d/0", lat, err, DIV_CYCLES); end
    n_checks++; if ({z_hi, z_lo} !== {32'd1, 32'd4}) begin n_fail++; $display("FAIL div_z: got %h expected %h", {z_hi, z_lo}, {32'd1, 32'd4}); end
  endtask

  task automatic test_illegal_op;
    int lat, cc, cb, bb; logic err, idle; logic [63:0] prev;
    prev = {z_hi, z_lo};
    run_op(4'd12, $urandom, $urandom, 1'b0, lat, err, cc, cb, bb, idle);
    n_checks++; if ({lat, err, cc} !== {32'd0, 1'b1, 32'd0}) begin n_fail++; $display("FAIL illegal_trap: got lat %0d err %b ctrl %0d expected 0/1/0", lat, err, cc); end
    n_checks++; if ({z_hi, z_lo} !== prev) begin n_fail++; $display("FAIL illegal_z_kept: got %h expected %h", {z_hi, z_lo}, prev); end
  endtask

  task automatic test_busy_start;
    int lat, cc, cb, bb; logic err, idle; logic [31:0] a, b; logic [63:0] exp;
    a = $urandom; b = $urandom; exp = ref_z(2, a, b);
    run_op(4'd2, a, b, 1'b1, lat, err, cc, cb, bb, idle);
    n_checks++; if ({lat, cc, cb} !== {MUL_CYCLES, MUL_CYCLES, 32'd0}) begin n_fail++; $display("FAIL busy_start_mul: got lat %0d ctrl %0d bad %0d", lat, cc, cb); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL busy_start_ignored: got idle %b expected 1", idle); end
    n_checks++; if ({z_hi, z_lo} !== exp) begin n_fail++; $display("FAIL busy_start_z: got %h expected %h", {z_hi, z_lo}, exp); end
    a = $urandom; b = $urandom; exp = ref_z(9, a, b);
    run_op(4'd9, a, b, 1'b0, lat, err, cc, cb, bb, idle);
    n_checks++; if ({lat, z_hi, z_lo} !== {32'd1, exp}) begin n_fail++; $display("FAIL back_to_back: got lat %0d z %h expected 1 %h", lat, {z_hi, z_lo}, exp); end
  endtask

  task automatic test_reset_mid_divide;
    int lat, cc, cb, bb, seen; logic err, idle;
    start = 1'b1; op = 4'd3; a_in = 32'd100; b_in = 32'd7;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    n_checks++; if ({alu_x, alu_y, alu_ctrl, z_hi, z_lo} !== '0) begin n_fail++; $display("FAIL midreset_regs: got %h expected 0", {alu_x, alu_y, alu_ctrl, z_hi, z_lo}); end
    n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags: got %b expected 000", {busy, done, error}); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) seen++; end
    clr = 1'b1;
    repeat (DIV_CYCLES + 2) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d bad cycles expected 0", seen); end
    run_op(4'd1, 32'd3, 32'd5, 1'b0, lat, err, cc, cb, bb, idle);
    n_checks++; if ({lat, z_hi, z_lo} !== {32'd1, 32'd0, 32'hFFFF_FFFE}) begin n_fail++; $display("FAIL midreset_sub: got lat %0d z %h expected 1 00000000fffffffe", lat, {z_hi, z_lo}); end
  endtask

  task automatic test_onehot_sweep;
    int lat, cc, cb, bb; logic err, idle; logic [31:0] a, b; logic [63:0] exp;
    for (int o = 0; o < 12; o++) begin
      a = $urandom; b = $urandom | 32'd1; exp = ref_z(o, a, b);
      run_op(4'(o), a, b, 1'b0, lat, err, cc, cb, bb, idle);
      n_checks++; if ({cc, cb, idle} !== {n_of(o), 32'd0, 1'b1}) begin n_fail++; $display("FAIL sweep_ctrl op%0d: got %0d cycles %0d bad idle %b expected %0d/0/1", o, cc, cb, idle, n_of(o)); end
      n_checks++; if ({lat, err, z_hi, z_lo} !== {n_of(o), 1'b0, exp}) begin n_fail++; $display("FAIL sweep_result op%0d: got lat %0d err %b z %h expected %0d 0 %h", o, lat, err, {z_hi, z_lo}, n_of(o), exp); end
    end
  endtask

  task automatic test_random;
    int lat, cc, cb, bb, o, n; logic err, idle, trap; logic [31:0] a, b; logic [63:0] exp;
    for (int k = 0; k < 40; k++) begin
      o = $urandom_range(0, 13);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      trap = (o >= 12) || (o == 3 && b == 0);
      exp = trap ? {z_hi, z_lo} : ref_z(o, a, b);
      n = trap ? 0 : n_of(o);
      run_op(4'(o), a, b, 1'b0, lat, err, cc, cb, bb, idle);
      n_checks++; if ({lat, err, cc, cb, idle} !== {n, trap, n, 32'd0, 1'b1}) begin n_fail++; $display("FAIL random_timing op%0d: got lat %0d err %b ctrl %0d bad %0d idle %b expected %0d %b %0d 0 1", o, lat, err, cc, cb, idle, n, trap, n); end
      n_checks++; if ({z_hi, z_lo} !== exp) begin n_fail++; $display("FAIL random_z op%0d: got %h expected %h", o, {z_hi, z_lo}, exp); end
    end
  endtask

  initial begin
    test_reset;
    @(negedge clk);
    test_add;
    test_multiply;
    test_div_by_zero;
    test_illegal_op;
    test_busy_start;
    test_reset_mid_divide;
    test_onehot_sweep;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sits in front of the combinational `alu` and sequences its operations. It accepts one operation request at a time, registers the operands, and drives the ALU's one-hot control vector for a per-operation settle time. It then captures the HI/LO results into the Z_HI/Z_LO result registers and signals completion. Multiply and divide get extended settle windows, and divide-by-zero or illegal opcodes are trapped without touching the result registers.

## Interface
- `BITS`, 32, datapath width.
- `SIG_COUNT`, 12, width of the ALU one-hot control vector.
- `MUL_CYCLES`, 4, EXEC cycles for multiply (op 2); legal values are 1 or more.
- `DIV_CYCLES`, 8, EXEC cycles for divide (op 3); legal values are 1 or more.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  4  operation index 0..11: add, sub, mul, div, shr, shl, ror, rol, and, or, neg, not.
- `a_in`, `b_in`  in  BITS  operands; sampled with `start`.
- `alu_x`, `alu_y`  out  BITS  registered operands driven to the ALU.
- `alu_ctrl`  out  SIG_COUNT  one-hot ALU control, with bit `op` set.
- `alu_hi`, `alu_lo`  in  BITS  ALU results.
- `z_hi`, `z_lo`  out  BITS  captured result registers.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  one-cycle pulse concurrent with `done`, for an illegal op or divide by zero.

## Operation
- States are IDLE, EXEC and DONE.
- **IDLE, start with a legal op:**
  - Latch `a_in`/`b_in` into `alu_x`/`alu_y`.
  - Set `alu_ctrl = 1 << op`.
  - Load the counter with N, where N = 1 for ops other than 2 and 3, `MUL_CYCLES` for op 2, and `DIV_CYCLES` for op 3.
  - Go to EXEC.
- **IDLE, start with op ≥ 12, or op 3 with `b_in == 0`:** go straight to DONE with `error` set. `alu_ctrl` stays 0 and `z_hi`/`z_lo` are unchanged.
- **EXEC:**
  - The counter decrements each edge.
  - On the edge where the counter equals 1, capture `z_lo <= alu_lo`.
  - On the same edge, `z_hi <= alu_hi` for ops 2 and 3; for all other ops `z_hi <= 0`, because the ALU HI output is undriven for them.
  - Go to DONE.
- **DONE:**
  - `done` = 1 for exactly one cycle, and `alu_ctrl` returns to 0.
  - Go to IDLE unconditionally.
  - `start` is ignored in DONE.
- `start` is ignored in EXEC and DONE; there is no queuing.
- `alu_x`/`alu_y` hold their values after completion until the next accepted start.
- `alu_ctrl` is never non-one-hot: it is either all zero or exactly one bit set.

## Timing
- **Reset** (`clr` low) takes effect immediately, regardless of clock:
  - state = IDLE and the counter = 0;
  - `alu_x`, `alu_y`, `alu_ctrl`, `z_hi`, `z_lo` = 0;
  - `busy`, `done`, `error` = 0.
- **Reset mid-operation** aborts the operation: no `done` pulse and no capture.
- **Legal op, latency:** with `start` sampled at edge T0, EXEC occupies N cycles and the capture happens at edge T0+N. `done` is high during cycle T0+N to T0+N+1.
- **Trapped op, latency:** `done` and `error` are high during cycle T0 to T0+1.
- `busy` is high from T0 until the edge that exits DONE.
- The earliest next accepted `start` is at the edge ending DONE plus one, giving a throughput of one operation per N+2 cycles.
- `z_hi`/`z_lo` are valid and stable from the `done` cycle onward until the next capture.
- Operand values presented while busy have no effect.

## Test plan
- **Add:** op 0, a=5, b=7 → `alu_ctrl` = 0x001 for 1 cycle; `z_lo` = 12, `z_hi` = 0; `done` one cycle, 1 cycle after the start edge; `error` = 0.
- **Multiply:** op 2, a=0x0001_0000, b=0x0001_0000, `MUL_CYCLES` = 4 → `alu_ctrl` = 0x004 held 4 cycles; `z_hi` = 1, `z_lo` = 0; `done` 4 cycles after the start edge.
- **Divide by zero:** op 3, a=9, b=0 → `done` and `error` one cycle later; `alu_ctrl` stays 0; `z_hi`/`z_lo` keep their previous values. Then op 3, a=9, b=2 → `done` after `DIV_CYCLES`, `error` = 0.
- **Illegal op:** op 12 → `error` and `done` pulse; no capture. `start` is pulsed every cycle during a multiply → only one `done`, and the second request is accepted only after IDLE is reached.
- **Reset mid-divide:** assert `clr` low two cycles into EXEC → all outputs 0 immediately, no `done`. After release, op 1 (a=3, b=5) gives `z_lo` = 0xFFFF_FFFE.
- **One-hot sweep:** ops 0..11 in sequence → in each EXEC, `alu_ctrl` equals `1 << op`, and `alu_ctrl` is 0 in IDLE and DONE.
